// File: rtl/plot_framebuffer_writer.sv
// plot_framebuffer_writer: clips plotted pixels, queues them in a FIFO and writes them (or a full-frame clear) to a stallable RAM port
module plot_framebuffer_writer #(
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int COL_W      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic [COL_W-1:0]  col,
  input  logic              plot,
  input  logic              clear_start,
  input  logic [COL_W-1:0]  clear_col,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [COL_W-1:0]  mem_data,
  output logic              mem_wren,
  input  logic              mem_ready,
  output logic              busy,
  output logic              clear_done,
  output logic              fifo_full,
  output logic              overflow,
  output logic [15:0]       clip_count,
  output logic [15:0]       drop_count,
  output logic [15:0]       pix_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
  state_t                    state;
  logic [ADDR_W+COL_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [PW:0]               count;
  logic [COL_W-1:0]          clr_col;
  logic                      in_range, push, pop, wdone;
  logic [ADDR_W-1:0]         lin_addr;
  assign in_range  = 32'(x) < 32'(H_RES) && 32'(y) < 32'(V_RES);
  assign lin_addr  = ADDR_W'(32'(y) * 32'(H_RES) + 32'(x));
  assign fifo_full = count == (PW+1)'(FIFO_DEPTH);
  assign push      = plot && in_range && !fifo_full;
  assign wdone     = mem_wren && mem_ready;
  // the port register refills on the same edge it completes, so there is no bubble
  assign pop       = state != CLEAR && count != '0 && (!mem_wren || mem_ready);
  always_ff @(posedge CLOCK_50)
    if (push) fifo_mem[wr_ptr] <= {lin_addr, col};
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      clr_col    <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wren   <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      overflow   <= 1'b0;
      clip_count <= '0;
      drop_count <= '0;
      pix_count  <= '0;
    end else begin
      clear_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (plot && !in_range && clip_count != 16'hFFFF) clip_count <= clip_count + 1'b1;
      if (plot && in_range && fifo_full) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end
      if (wdone && state != CLEAR && pix_count != 16'hFFFF) pix_count <= pix_count + 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            mem_wren              <= 1'b1;
            {mem_addr, mem_data}  <= fifo_mem[rd_ptr];
          end else if (wdone) mem_wren <= 1'b0;
          if (clear_start) begin
            clr_col <= clear_col;
            busy    <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop) begin
            mem_wren              <= 1'b1;
            {mem_addr, mem_data}  <= fifo_mem[rd_ptr];
          end else if (count == '0 && (!mem_wren || mem_ready)) begin
            mem_wren <= 1'b1;
            mem_addr <= '0;
            mem_data <= clr_col;
            state    <= CLEAR;
          end
        end
        default: begin
          if (mem_ready) begin
            if (mem_addr == LAST) begin
              mem_wren   <= 1'b0;
              busy       <= 1'b0;
              clear_done <= 1'b1;
              state      <= IDLE;
            end else mem_addr <= mem_addr + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_plot_framebuffer_writer.sv
// tb_plot_framebuffer_writer: table vectors plus hand sequences, write port checked against an expected-write queue
module tb_plot_framebuffer_writer;
  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [2:0]  col = '0;
  logic        plot = 1'b0;
  logic        clear_start = 1'b0;
  logic [2:0]  clear_col = '0;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_wren;
  logic        mem_ready = 1'b1;
  logic        busy, clear_done, fifo_full, overflow;
  logic [15:0] clip_count, drop_count, pix_count;

  plot_framebuffer_writer dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .x(x), .y(y), .col(col), .plot(plot),
    .clear_start(clear_start), .clear_col(clear_col), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_ready(mem_ready), .busy(busy),
    .clear_done(clear_done), .fifo_full(fifo_full), .overflow(overflow),
    .clip_count(clip_count), .drop_count(drop_count), .pix_count(pix_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int x; int y; int col; bit ok; int addr; int clip; } vec_t;
  wr_t  exp_q[$];
  vec_t tbl[7];
  int   total = 0;
  int   bad = 0;
  bit   sb_on = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_exp(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  always @(negedge CLOCK_50) begin
    if (sb_on && !reset && mem_wren && mem_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write: unexpected write addr=%0d data=%0d", mem_addr, mem_data);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if (int'(mem_addr) != w.addr || int'(mem_data) != w.data) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   mem_addr, mem_data, w.addr, w.data);
        end
      end
    end
  end

  initial begin
    int pulses;
    tbl[0] = '{160, 0,   1, 1'b0, 0,     1};
    tbl[1] = '{0,   120, 2, 1'b0, 0,     2};
    tbl[2] = '{159, 119, 3, 1'b1, 19199, 2};
    tbl[3] = '{0,   0,   4, 1'b1, 0,     2};
    tbl[4] = '{255, 127, 5, 1'b0, 0,     3};
    tbl[5] = '{159, 0,   6, 1'b1, 159,   3};
    tbl[6] = '{0,   119, 7, 1'b1, 19040, 3};

    tick(); tick();
    reset = 1'b0;
    chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pix", pix_count, 0);

    x = 5; y = 2; col = 3'b101; plot = 1'b1;
    push_exp(325, 5);
    tick();
    plot = 1'b0;
    chk("lat_n_wren", mem_wren, 0);
    tick();
    chk("lat_n1_wren", mem_wren, 1);
    chk("lat_n1_addr", mem_addr, 325);
    chk("lat_n1_data", mem_data, 5);
    tick();
    chk("lat_n2_wren", mem_wren, 0);
    chk("single_pix", pix_count, 1);

    for (int i = 0; i < 7; i++) begin
      x = 8'(tbl[i].x); y = 7'(tbl[i].y); col = 3'(tbl[i].col); plot = 1'b1;
      if (tbl[i].ok) push_exp(tbl[i].addr, tbl[i].col);
      tick();
      plot = 1'b0;
      repeat (3) tick();
      chk($sformatf("clip_vec%0d", i), clip_count, tbl[i].clip);
    end
    chk("tbl_pix", pix_count, 5);

    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      x = 8'(i); y = 7'd10; col = 3'(i); plot = 1'b1;
      if (i < 5) push_exp(1600 + i, i);
      tick();
    end
    plot = 1'b0;
    chk("ovf_drop", drop_count, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_full", fifo_full, 1);
    chk("ovf_port_addr", mem_addr, 1600);
    tick();
    chk("ovf_hold_addr", mem_addr, 1600);
    mem_ready = 1'b1;
    repeat (8) tick();
    chk("ovf_pix", pix_count, 10);
    chk("ovf_full_after", fifo_full, 0);

    mem_ready = 1'b0;
    x = 3; y = 3; col = 3'd1; plot = 1'b1;
    push_exp(483, 1);
    tick();
    plot = 1'b0;
    tick();
    chk("stall_addr0", mem_addr, 483);
    tick();
    chk("stall_addr1", mem_addr, 483);
    chk("stall_data1", mem_data, 1);
    chk("stall_wren1", mem_wren, 1);
    mem_ready = 1'b1;
    tick();
    chk("stall_done_wren", mem_wren, 0);
    repeat (3) tick();
    chk("stall_pix", pix_count, 11);

    x = 10; y = 0; col = 3'd7; plot = 1'b1;
    push_exp(10, 7);
    tick();
    x = 11; col = 3'd6; clear_start = 1'b1; clear_col = 3'b010;
    push_exp(11, 6);
    for (int a = 0; a < 19200; a++) push_exp(a, 2);
    tick();
    plot = 1'b0; clear_start = 1'b0;
    chk("clr_busy", busy, 1);
    pulses = 0;
    for (int i = 0; i < 40000 && pulses == 0; i++) begin
      mem_ready = ($urandom_range(3) != 0);
      tick();
      if (clear_done) begin
        pulses++;
        chk("clr_busy_fall", busy, 0);
      end
    end
    mem_ready = 1'b1;
    chk("clr_pulses", pulses, 1);
    tick();
    chk("clr_pulse_len", clear_done, 0);
    chk("clr_queue", exp_q.size(), 0);
    chk("clr_pix", pix_count, 13);

    sb_on = 1'b0;
    clear_start = 1'b1; clear_col = 3'd5;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 500 && !(busy && mem_wren && mem_addr == 15'd100); i++) tick();
    chk("mid_reached", mem_addr, 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_wren", mem_wren, 0);
    chk("mid_busy", busy, 0);
    chk("mid_pix", pix_count, 0);
    chk("mid_clip", clip_count, 0);
    chk("mid_drop", drop_count, 0);
    chk("mid_ovf", overflow, 0);
    exp_q.delete();
    sb_on = 1'b1;
    x = 1; y = 0; col = 3'd4; plot = 1'b1;
    push_exp(1, 4);
    tick();
    plot = 1'b0;
    chk("post_n_wren", mem_wren, 0);
    tick();
    chk("post_wren", mem_wren, 1);
    chk("post_addr", mem_addr, 1);
    tick(); tick();
    chk("post_pix", pix_count, 1);
    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/plot_framebuffer_writer.md
Name: plot_framebuffer_writer

Overview:
Receiving end of the pixel-plot interface (x, y, col, plot) that the display modules drive. It accepts one pixel per plot strobe and drops out-of-range coordinates. Accepted pixels are buffered in a small FIFO and converted to a linear framebuffer address. Writes are issued to a single-port frame RAM through a stallable write port. It also contains a clear engine that fills the whole frame with one colour, and status counters for debugging on the board.

Parameters:
H_RES, 160, horizontal pixels; valid x is 0..H_RES-1
V_RES, 120, vertical pixels; valid y is 0..V_RES-1
COL_W, 3, colour width in bits
FIFO_DEPTH, 4, pixel FIFO entries (power of 2, >=2)
ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
CLOCK_50  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
x  in  8  pixel column from the plot source
y  in  7  pixel row from the plot source
col  in  COL_W  pixel colour
plot  in  1  pixel-valid strobe, sampled every edge; there is no backpressure to the source
clear_start  in  1  one-cycle request to fill the frame with clear_col
clear_col  in  COL_W  fill colour, sampled with clear_start
mem_addr  out  ADDR_W  framebuffer write address
mem_data  out  COL_W  framebuffer write data
mem_wren  out  1  write request
mem_ready  in  1  RAM accepts the write this cycle (low = stall, e.g. scan-out arbitration)
busy  out  1  clear in progress, including its drain phase
clear_done  out  1  one-cycle pulse when the clear finishes
fifo_full  out  1  FIFO occupancy == FIFO_DEPTH
overflow  out  1  sticky; set when a valid plot is dropped because the FIFO is full
clip_count  out  16  plots rejected as out of range, saturating
drop_count  out  16  plots dropped because the FIFO is full, saturating
pix_count  out  16  pixel writes completed (not clear writes), saturating

Behaviour:
- Reset (synchronous, sampled on an edge with reset=1):
  - FIFO emptied; state = IDLE.
  - mem_wren=0, mem_addr=0, mem_data=0.
  - busy=0, clear_done=0, fifo_full=0, overflow=0, all counters 0.
  - Any in-flight write or clear is abandoned. mem_wren is 0 from the first edge with reset=1.
- Input stage, on every edge with plot=1, checked in this order:
  - x>=H_RES or y>=V_RES: discard, clip_count+1.
  - Else FIFO full (registered occupancy == FIFO_DEPTH): discard, drop_count+1, overflow<=1. A pop on the same edge does not make room; there is no bypass.
  - Else push {y*H_RES+x, col}. The address is computed at push time, truncated to ADDR_W.
- Write port handshake:
  - A write completes on an edge where mem_wren=1 and mem_ready=1.
  - While mem_wren=1 and mem_ready=0, mem_addr and mem_data are held stable.
  - After a completing edge, the next write may be presented immediately, so there is no bubble and back-to-back writes run at one per cycle.
- Pixel latency:
  - With the FIFO empty and the port idle, a pixel sampled at edge N pops at edge N+1.
  - mem_wren=1 from edge N+1 with that pixel's address and data.
- Ordering: pixels are written in arrival order. pix_count increments once per completed pixel write.
- State machine:
  - IDLE: pops FIFO entries to the write port.
    - clear_start=1: latch clear_col, busy<=1, go to DRAIN.
  - DRAIN: keeps issuing FIFO entries until the FIFO is empty and no write is pending, then goes to CLEAR with clear address = 0.
  - CLEAR:
    - Presents addr = clear address, data = latched colour, mem_wren=1.
    - Each completed write increments the address.
    - The completion at address H_RES*V_RES-1 sets busy<=0, pulses clear_done for one cycle, and returns to IDLE.
    - FIFO entries are not popped during CLEAR.
- Plots arriving during DRAIN or CLEAR are still classified and pushed; the normal drop rules apply.
- clear_start while busy=1 is ignored.
- clear_start and plot on the same edge: the plot is pushed first, so it is drained before the clear and then overwritten by it.
- All counters saturate at 16'hFFFF; overflow clears only on reset.

Test Plan:
- Single pixel: reset, then plot x=5,y=2,col=3'b101 at edge N with mem_ready=1 -> mem_wren=1, mem_addr=325, mem_data=5 from edge N+1 for exactly one cycle; pix_count=1.
- Clipping: plot (160,0), (0,120) and (159,119) -> clip_count=2; one write with addr 19199.
- Overflow: mem_ready=0, plot 6 consecutive valid pixels -> 5 accepted (4 in FIFO plus 1 held on the port), 1 dropped; drop_count=1, overflow=1, fifo_full=1. Then mem_ready=1 -> 5 writes in arrival order.
- Stall hold: mem_ready toggled 0,0,1 during a write -> mem_addr and mem_data unchanged across the stall; exactly one completion.
- Clear: 2 pixels queued, then clear_start with clear_col=3'b010 -> both pixel writes first, then 19200 writes at addresses 0..19199 with data 2. clear_done pulses once; busy falls on the same edge.
- Mid-clear reset: assert reset at clear address 100 -> mem_wren=0, busy=0 and counters 0 after that edge; a following plot (1,0) gives addr 1 with the normal latency.
